// File: rtl/req_ack_sync_fifo_pkg.sv
// Shared types and defaults for the req/ack synchronous FIFO (package fifo_pkg).
// Handshake FSM encoding plus default width/depth used by the top module.
package fifo_pkg;

  typedef enum logic {
    HS_IDLE     = 1'b0,
    HS_WAIT_REL = 1'b1
  } hs_state_e;

  localparam int FIFO_DEF_WIDTH = 32;
  localparam int FIFO_DEF_DEPTH = 16;

endpackage

// File: rtl/req_ack_sync_fifo_port.sv
// One req/ack handshake port: single-shot (one transfer per req assertion)
// or stream (one transfer per cycle while req is held and cond allows it).
module req_ack_port
  import fifo_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic stream_mode,
  input  logic cond,
  output logic ack,
  output logic ack_pulse
);

  hs_state_e state_q, state_d;
  logic      ack_pulse_q;

  assign ack       = req & cond & (state_q == HS_IDLE);
  assign ack_pulse = ack_pulse_q;

  always_comb begin
    // NOTE: default assignment first so no path through the case leaves state_d unassigned (no latch).
    state_d = state_q;
    case (state_q)
      HS_IDLE:     if (ack && !stream_mode) state_d = HS_WAIT_REL;
      HS_WAIT_REL: if (!req) state_d = HS_IDLE;
      default:     state_d = HS_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= HS_IDLE;
      ack_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ack_pulse_q <= ack;
    end
  end

endmodule

// File: rtl/req_ack_sync_fifo.sv
// Single-clock circular FIFO with req/ack push and pop ports, first-word fall-through.
// Optional REQ_ACK_FIFO_LEVEL_EN adds a registered occupancy output fifo_level.
module req_ack_sync_fifo
  import fifo_pkg::*;
#(
  parameter  int WIDTH = FIFO_DEF_WIDTH,
  parameter  int DEPTH = FIFO_DEF_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_req,
  input  logic             push_stream_mode,
  input  logic [WIDTH-1:0] push_data_in,
  output logic             push_ack,
  output logic             push_ack_pulse,
  output logic             fifo_full,
  input  logic             pop_req,
  input  logic             pop_stream_mode,
  output logic             pop_ack,
  output logic             pop_ack_pulse,
  output logic [WIDTH-1:0] pop_data_out,
  output logic             fifo_empty
`ifdef REQ_ACK_FIFO_LEVEL_EN
  ,
  output logic [AW:0]      fifo_level
`endif
);

  localparam logic [AW:0] PTR_ONE  = (AW + 1)'(1);
  localparam logic [AW:0] FULL_XOR = {1'b1, {AW{1'b0}}};

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             seen_wr_q;

  req_ack_port u_push_port (
    .clk         (clk),
    .rst         (rst),
    .req         (push_req),
    .stream_mode (push_stream_mode),
    .cond        (~full_q),
    .ack         (push_ack),
    .ack_pulse   (push_ack_pulse)
  );

  req_ack_port u_pop_port (
    .clk         (clk),
    .rst         (rst),
    .req         (pop_req),
    .stream_mode (pop_stream_mode),
    .cond        (~empty_q),
    .ack         (pop_ack),
    .ack_pulse   (pop_ack_pulse)
  );

  // Flags are computed from the next pointers so they are registered but never lag a transfer.
  always_comb begin
    wr_ptr_d = push_ack ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d = pop_ack  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    full_d   = ((wr_ptr_d ^ rd_ptr_d) == FULL_XOR);
    empty_d  = (wr_ptr_d == rd_ptr_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      seen_wr_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
      if (push_ack) seen_wr_q <= 1'b1;
    end
  end

  // NOTE: the storage array has no reset; reset only blocks the write so stale data stays put.
  always_ff @(posedge clk) begin
    if (push_ack && !rst) mem_q[wr_ptr_q[AW-1:0]] <= push_data_in;
  end

  // Stale contents surviving a reset are hidden until the first new write.
  assign pop_data_out = seen_wr_q ? mem_q[rd_ptr_q[AW-1:0]] : '0;
  assign fifo_full    = full_q;
  assign fifo_empty   = empty_q;

`ifdef REQ_ACK_FIFO_LEVEL_EN
  logic [AW:0] level_q, level_d;

  always_comb begin
    level_d = level_q;
    case ({push_ack, pop_ack})
      2'b10:   level_d = level_q + PTR_ONE;
      2'b01:   level_d = level_q - PTR_ONE;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) level_q <= '0;
    else     level_q <= level_d;
  end

  assign fifo_level = level_q;
`endif

endmodule
